aes_key_expand: RTL

AES-128 key-expansion engine that sits directly upstream of `aes_sbox`. It drives the S-box word input with the last word of the previous round key and consumes the substituted word to build the next round key. The block generates all 11 round keys (rounds 0–10), one per cycle after a start pulse. It stores them for random-access reads by the encipher/decipher datapath.

---
 rtl/aes_key_expand.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : AES-128 key schedule engine. Produces round keys 0..10, one
//               per cycle, using an external S-box, and holds them for reads.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    localparam int unsigned C_NUM_KEYS   = 11;
    localparam logic [3:0]  C_LAST_ROUND = 4'd10;
    localparam logic [7:0]  C_RCON_INIT  = 8'h01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_mem_q [0:C_NUM_KEYS-1];
    logic [127:0]   prev_key_q, prev_key_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     round_ctr_q, round_ctr_d;
    logic           ready_q, ready_d;

    logic           w_mem_we;
    logic [3:0]     w_mem_waddr;
    logic [127:0]   w_mem_wdata;

    logic [31:0]    w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_nk;
    logic [7:0]     w_rcon_next;

    // The S-box output is rotated after substitution; byte-wise SubWord
    // commutes with RotWord, so this matches the reference ordering.
    assign w_t  = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h000000};
    assign w_n0 = prev_key_q[127:96] ^ w_t;
    assign w_n1 = prev_key_q[95:64]  ^ w_n0;
    assign w_n2 = prev_key_q[63:32]  ^ w_n1;
    assign w_n3 = prev_key_q[31:0]   ^ w_n2;
    assign w_nk = {w_n0, w_n1, w_n2, w_n3};

    assign w_rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    assign sboxw = prev_key_q[31:0];
    assign ready = ready_q;

    always_comb begin
        state_d     = state_q;
        prev_key_d  = prev_key_q;
        rcon_d      = rcon_q;
        round_ctr_d = round_ctr_q;
        ready_d     = ready_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = 4'd0;
        w_mem_wdata = w_nk;

        case (state_q)
            IDLE: begin
                if (init) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = 4'd0;
                    w_mem_wdata = key;
                    prev_key_d  = key;
                    rcon_d      = C_RCON_INIT;
                    round_ctr_d = 4'd1;
                    ready_d     = 1'b0;
                    state_d     = GEN;
                end
            end
            GEN: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = round_ctr_q;
                w_mem_wdata = w_nk;
                prev_key_d  = w_nk;
                rcon_d      = w_rcon_next;
                round_ctr_d = round_ctr_q + 4'd1;
                if (round_ctr_q == C_LAST_ROUND) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prev_key_q  <= '0;
            rcon_q      <= C_RCON_INIT;
            round_ctr_q <= 4'd0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_key_q  <= prev_key_d;
            rcon_q      <= rcon_d;
            round_ctr_q <= round_ctr_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < C_NUM_KEYS; i++) begin
                key_mem_q[i] <= '0;
            end
        end else if (w_mem_we) begin
            for (int i = 0; i < C_NUM_KEYS; i++) begin
                if (w_mem_waddr == i[3:0]) begin
                    key_mem_q[i] <= w_mem_wdata;
                end
            end
        end
    end

    // Indices 11..15 have no storage behind them and read as zero.
    always_comb begin
        round_key = '0;
        for (int i = 0; i < C_NUM_KEYS; i++) begin
            if (round == i[3:0]) begin
                round_key = key_mem_q[i];
            end
        end
    end

endmodule
`default_nettype wire
